// File: rtl/ram_burst_if.sv
// ram_burst_if: command, write-data and read-data handshake channels of ram_burst_ctrl.
// master = burst requester (drives commands and write words, consumes read words);
// slave  = ram_burst_ctrl.
interface ram_burst_if #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH-1:0] cmd_len;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready,
        output wr_valid, wr_data,
        input  wr_ready,
        input  rd_valid, rd_data,
        output rd_ready
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready,
        input  wr_valid, wr_data,
        output wr_ready,
        output rd_valid, rd_data,
        input  rd_ready
    );
endinterface

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst sequencer owning the addr/data/we port of a single-port RAM.
// Write bursts stream words straight into the RAM; read bursts issue addresses and
// collect the one-cycle-late RAM output in a two-entry buffer with valid/ready output.
// Optional feature: define RAM_BURST_ABORT_EN to add the 'abort' input.
module ram_burst_ctrl #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_burst_if.slave            bus,
`ifdef RAM_BURST_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    // remaining must hold 2^ADDR_WIDTH for a full-length burst
    localparam int unsigned REM_WIDTH = ADDR_WIDTH + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [REM_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic                  done_q, done_d;

    logic abort_c;
    logic rd_valid_c;
    logic pop_c;
    logic wr_hs_c;
    logic issue_c;

`ifdef RAM_BURST_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // Handshake and issue qualifiers; issuing keeps occupancy plus in-flight reads within two
    assign rd_valid_c = !rst && (count_q != 2'd0);
    assign pop_c      = rd_valid_c && bus.rd_ready;
    assign wr_hs_c    = !rst && (state_q == S_WRITE) && !abort_c && bus.wr_valid;
    assign issue_c    = !rst && (state_q == S_READ) && !abort_c
                        && (remaining_q != '0)
                        && ((3'(count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop_c)));

    // Port outputs; RAM port is combinational so the RAM writes on the handshake edge
    assign bus.cmd_ready = !rst && (state_q == S_IDLE);
    assign bus.wr_ready  = !rst && (state_q == S_WRITE);
    assign bus.rd_valid  = rd_valid_c;
    assign bus.rd_data   = rst ? '0 : buf0_q;
    assign busy          = !rst && (state_q != S_IDLE);
    assign done          = !rst && done_q;
    assign ram_we        = wr_hs_c;
    assign ram_addr      = rst ? '0 : cur_addr_q;
    assign ram_data      = (!rst && (state_q == S_WRITE)) ? bus.wr_data : '0;

    // Next-state logic: output buffer push/pop, then burst FSM
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        inflight_d  = issue_c;
        count_d     = count_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        done_d      = 1'b0;

        case ({inflight_q, pop_c})
            2'b10: begin
                if (count_q == 2'd0) begin
                    buf0_d = ram_q;
                end else begin
                    buf1_d = ram_q;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                buf0_d  = buf1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    buf0_d = ram_q;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = ram_q;
                end
            end
            default: ;
        endcase

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    cur_addr_d  = bus.cmd_addr;
                    remaining_d = REM_WIDTH'(bus.cmd_len) + REM_WIDTH'(1);
                    state_d     = bus.cmd_write ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (abort_c) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (wr_hs_c) begin
                    cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - REM_WIDTH'(1);
                    if (remaining_q == REM_WIDTH'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (abort_c) begin
                    state_d = S_DRAIN;
                end else if (issue_c) begin
                    cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - REM_WIDTH'(1);
                    if (remaining_q == REM_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            default: begin
                if (!inflight_q && (count_d == 2'd0)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    // State registers with synchronous reset; reset drops any burst and flushes the buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            count_q     <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: self-checking bench for ram_burst_ctrl with a behavioural RAM and
// a word-level reference memory. Define RAM_BURST_ABORT_EN to also exercise 'abort'.
module tb_ram_burst_ctrl;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_burst_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic          busy, done, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data, ram_q;
`ifdef RAM_BURST_ABORT_EN
    logic          abort;
`endif

    ram_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
`ifdef RAM_BURST_ABORT_EN
        .abort    (abort),
`endif
        .busy     (busy),
        .done     (done),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_we   (ram_we),
        .ram_q    (ram_q)
    );

    // Behavioural single-port RAM with registered read output
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_data;
        ram_q <= ram_mem[ram_addr];
    end

    int unsigned ram_wr_count = 0;
    always @(posedge clk) if (ram_we) ram_wr_count <= ram_wr_count + 1;

    // Reference contents: what each RAM word should hold after the bursts so far
    logic [DW-1:0] ref_mem [DEPTH];
    int n_checks = 0;
    int n_pass   = 0;

    // Write burst; starts in the low clock phase with the block idle
    task automatic write_burst(input logic [AW-1:0] addr, input int len, input int gap_pct,
                               input int dir_base);
        int n, i, cyc;
        logic v;
        logic [DW-1:0] d;
        logic [AW-1:0] exp_addr;
        n = len + 1; i = 0; cyc = 0;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = addr; bus.cmd_len = AW'(len);
        #1;
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL wr_cmd_ready: got %b exp 1", bus.cmd_ready); else n_pass++;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        while (i < n && cyc < 1000) begin
            v = ($urandom_range(99) >= gap_pct);
            d = (dir_base >= 0) ? DW'(dir_base + i) : DW'($urandom);
            exp_addr = AW'(int'(addr) + i);
            bus.wr_valid = v; bus.wr_data = d;
            #1;
            n_checks++; if (bus.wr_ready !== 1'b1) $display("FAIL wr_ready: got %b exp 1", bus.wr_ready); else n_pass++;
            n_checks++; if (ram_we !== v) $display("FAIL wr_ram_we: got %b exp %b", ram_we, v); else n_pass++;
            n_checks++; if (done !== 1'b0) $display("FAIL wr_done_early: got %b exp 0", done); else n_pass++;
            if (v) begin
                n_checks++; if (ram_addr !== exp_addr) $display("FAIL wr_ram_addr: got %0d exp %0d", ram_addr, exp_addr); else n_pass++;
                n_checks++; if (ram_data !== d) $display("FAIL wr_ram_data: got %h exp %h", ram_data, d); else n_pass++;
                ref_mem[exp_addr] = d;
                i++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.wr_valid = 1'b0;
        n_checks++; if (i != n) $display("FAIL wr_timeout: got %0d words exp %0d", i, n); else n_pass++;
        #1;
        n_checks++; if (done !== 1'b1) $display("FAIL wr_done: got %b exp 1", done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL wr_busy_end: got %b exp 0", busy); else n_pass++;
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL wr_cmd_ready_end: got %b exp 1", bus.cmd_ready); else n_pass++;
    endtask

    // Read burst with random consumer backpressure after 'stall' forced-low cycles
    task automatic read_burst(input logic [AW-1:0] addr, input int len, input int ready_pct,
                              input int stall);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] held;
        logic rr, hold;
        int n, popped, cyc;
        n = len + 1; popped = 0; cyc = 0; hold = 1'b0; held = '0;
        for (int j = 0; j < n; j++) exp_q.push_back(ref_mem[AW'(int'(addr) + j)]);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = addr; bus.cmd_len = AW'(len);
        #1;
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL rd_cmd_ready: got %b exp 1", bus.cmd_ready); else n_pass++;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        while (popped < n && cyc < 1000) begin
            rr = (cyc >= stall) && ($urandom_range(99) < ready_pct);
            bus.rd_ready = rr;
            #1;
            if (cyc < 2) begin
                n_checks++; if (bus.rd_valid !== 1'b0) $display("FAIL rd_latency_early: cyc %0d got %b exp 0", cyc, bus.rd_valid); else n_pass++;
            end
            if (cyc == 2) begin
                n_checks++; if (bus.rd_valid !== 1'b1) $display("FAIL rd_latency_first: got %b exp 1", bus.rd_valid); else n_pass++;
            end
            if (ready_pct == 100 && stall == 0 && cyc >= 2) begin
                n_checks++; if (bus.rd_valid !== 1'b1) $display("FAIL rd_throughput: cyc %0d got %b exp 1", cyc, bus.rd_valid); else n_pass++;
            end
            if (hold) begin
                n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== held) $display("FAIL rd_hold_stable: got %b/%h exp 1/%h", bus.rd_valid, bus.rd_data, held); else n_pass++;
            end
            if (stall >= 3 && n >= 3 && cyc == stall - 1) begin
                n_checks++; if (ram_addr !== AW'(int'(addr) + 2)) $display("FAIL rd_issue_limit: got %0d exp %0d", ram_addr, AW'(int'(addr) + 2)); else n_pass++;
            end
            n_checks++; if (done !== 1'b0) $display("FAIL rd_done_early: got %b exp 0", done); else n_pass++;
            if (bus.rd_valid === 1'b1 && rr) begin
                n_checks++; if (bus.rd_data !== exp_q[popped]) $display("FAIL rd_data: word %0d got %h exp %h", popped, bus.rd_data, exp_q[popped]); else n_pass++;
                popped++;
            end
            hold = (bus.rd_valid === 1'b1) && !rr;
            held = bus.rd_data;
            @(negedge clk);
            cyc++;
        end
        bus.rd_ready = 1'b0;
        n_checks++; if (popped != n) $display("FAIL rd_timeout: got %0d words exp %0d", popped, n); else n_pass++;
        #1;
        n_checks++; if (done !== 1'b1) $display("FAIL rd_done: got %b exp 1", done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rd_busy_end: got %b exp 0", busy); else n_pass++;
        n_checks++; if (bus.rd_valid !== 1'b0) $display("FAIL rd_valid_end: got %b exp 0", bus.rd_valid); else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (bus.cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b exp 0", bus.cmd_ready); else n_pass++;
        n_checks++; if (bus.wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b exp 0", bus.wr_ready); else n_pass++;
        n_checks++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b exp 0", bus.rd_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done: got %b%b exp 00", busy, done); else n_pass++;
        n_checks++; if (ram_we !== 1'b0 || ram_addr !== '0 || ram_data !== '0) $display("FAIL reset_ram_port: got %b/%0d/%h exp 0/0/00", ram_we, ram_addr, ram_data); else n_pass++;
        n_checks++; if (bus.rd_data !== '0) $display("FAIL reset_rd_data: got %h exp 00", bus.rd_data); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset_release_cmd_ready: got %b exp 1", bus.cmd_ready); else n_pass++;
    endtask

    task automatic test_write_basic();
        int base;
        base = int'(ram_wr_count);
        write_burst(AW'(0), 2, 0, 1);
        n_checks++; if (int'(ram_wr_count) - base != 3) $display("FAIL write_basic_count: got %0d exp 3", int'(ram_wr_count) - base); else n_pass++;
    endtask

    task automatic test_read_basic();
        read_burst(AW'(0), 2, 100, 0);
    endtask

    task automatic test_backpressure();
        read_burst(AW'(0), 2, 100, 4);
    endtask

    task automatic test_wrap();
        write_burst(AW'(62), 3, 0, 'hA0);
        read_burst(AW'(62), 3, 100, 0);
    endtask

    task automatic test_full_length();
        write_burst(AW'($urandom), 63, 20, -1);
        read_burst(AW'($urandom), 63, 70, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(1) == 1)
                write_burst(AW'($urandom), int'($urandom_range(15)), int'($urandom_range(50)), -1);
            else
                read_burst(AW'($urandom), int'($urandom_range(15)), int'($urandom_range(100, 30)), 0);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        a = AW'($urandom);
        write_burst(a, 5, 0, -1);
        read_burst(a, 5, 100, 0);
        read_burst(a, 0, 100, 0);
    endtask

    task automatic test_reset_mid_read();
        bus.rd_ready = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = AW'(0); bus.cmd_len = AW'(7);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_checks++; if (bus.rd_valid !== 1'b1 || busy !== 1'b1) $display("FAIL midrst_setup: got %b%b exp 11", bus.rd_valid, busy); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (bus.rd_valid !== 1'b0) $display("FAIL midrst_rd_valid: got %b exp 0", bus.rd_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0 || ram_we !== 1'b0 || done !== 1'b0) $display("FAIL midrst_state: got busy %b we %b done %b exp 000", busy, ram_we, done); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++; if (bus.cmd_ready !== 1'b1 || done !== 1'b0 || bus.rd_valid !== 1'b0) $display("FAIL midrst_after: got rdy %b done %b vld %b exp 100", bus.cmd_ready, done, bus.rd_valid); else n_pass++;
    endtask

`ifdef RAM_BURST_ABORT_EN
    task automatic test_abort();
        int base;
        logic [DW-1:0] d;
        base = int'(ram_wr_count);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = AW'(20); bus.cmd_len = AW'(7);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d = DW'($urandom);
            bus.wr_valid = 1'b1; bus.wr_data = d;
            ref_mem[AW'(20 + i)] = d;
            @(negedge clk);
        end
        abort = 1'b1;
        #1;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL abort_we: got %b exp 0", ram_we); else n_pass++;
        @(negedge clk);
        abort = 1'b0; bus.wr_valid = 1'b0;
        #1;
        n_checks++; if (done !== 1'b1 || bus.cmd_ready !== 1'b1) $display("FAIL abort_done: got done %b rdy %b exp 11", done, bus.cmd_ready); else n_pass++;
        n_checks++; if (int'(ram_wr_count) - base != 2) $display("FAIL abort_write_count: got %0d exp 2", int'(ram_wr_count) - base); else n_pass++;
        read_burst(AW'(20), 1, 100, 0);
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
`ifdef RAM_BURST_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_write_basic();
        test_read_basic();
        test_backpressure();
        test_wrap();
        test_full_length();
        test_random();
        test_back_to_back();
        test_reset_mid_read();
`ifdef RAM_BURST_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Burst sequencer that sits directly upstream of `single_port_ram` and owns its `addr`/`data`/`we` port while consuming its `q` output. It accepts one burst command at a time (write or read, base address, length), streams write words in through a valid/ready port, issues the read addresses itself, and returns read words through a backpressured valid/ready port. A two-entry output buffer absorbs the RAM's one-cycle read latency.

## Interface
- `ADDR_WIDTH`, 6, RAM address width; must equal the RAM's `addr_width`.
- `DATA_WIDTH`, 8, word width; must equal the RAM's `data_width`.

- `clk` in 1: single clock, shared with the RAM.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when both this and `cmd_valid` are high.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in ADDR_WIDTH: burst base address.
- `cmd_len` in ADDR_WIDTH: word count minus 1, giving 1..2^ADDR_WIDTH words.
- `wr_valid` in 1: write word offered.
- `wr_ready` out 1: write word accepted.
- `wr_data` in DATA_WIDTH: write word.
- `rd_valid` out 1: read word available.
- `rd_ready` in 1: consumer takes the read word.
- `rd_data` out DATA_WIDTH: read word, the head of the output buffer.
- `busy` out 1: high whenever the block is not IDLE.
- `done` out 1: one-cycle pulse when a burst completes.
- `ram_addr` out ADDR_WIDTH: drives RAM `addr`.
- `ram_data` out DATA_WIDTH: drives RAM `data`.
- `ram_we` out 1: drives RAM `we`.
- `ram_q` in DATA_WIDTH: from RAM `q`. It is valid the cycle after the address is sampled.

## Operation
- **States:** IDLE, WRITE, READ, DRAIN.
- **IDLE:**
  - `cmd_ready`=1.
  - On a command handshake, latch `cur_addr`=`cmd_addr` and `remaining`=`cmd_len`+1.
  - Go to WRITE if `cmd_write`=1, otherwise READ.
- **WRITE:**
  - `wr_ready`=1.
  - `ram_we` = `wr_valid`, `ram_addr` = `cur_addr`, `ram_data` = `wr_data`. These are combinational, so the RAM writes on the handshake edge.
  - On each handshake, `cur_addr`+1 and `remaining`−1.
  - On the last handshake, go to IDLE and pulse `done` in the following cycle.
- **READ:**
  - Issue a read (`ram_addr`=`cur_addr`, `ram_we`=0) when `remaining`>0 and `count + inflight − pop < 2`.
    - `count` = buffer occupancy (0..2).
    - `inflight` = 1 if a read was issued on the previous edge.
    - `pop` = `rd_valid & rd_ready`.
  - Each issue decrements `remaining` and increments `cur_addr`.
  - `ram_q` is pushed into the buffer on the edge after the issue edge.
  - When `remaining` reaches 0, go to DRAIN.
- **DRAIN:**
  - No further issues.
  - When the buffer is empty, nothing is in flight, and the last word has popped, go to IDLE and pulse `done`.
- **Address arithmetic:** `cur_addr` wraps modulo 2^ADDR_WIDTH; 63 → 0 at the default width.
- **Idle RAM port:** when not issuing or writing, `ram_we`=0 and `ram_addr` holds `cur_addr`.
- **Commands while busy:** `cmd_ready`=0, so they are not accepted.
- **Reset values:**
  - `cmd_ready`=0 while `rst` is high, 1 in the first cycle after.
  - `wr_ready`=0, `rd_valid`=0, `busy`=0, `done`=0, `ram_we`=0, `ram_addr`=0, `ram_data`=0, `rd_data`=0.
  - The buffer is flushed.
- **Reset mid-burst:** same as above. The burst is dropped, no `ram_we` is asserted after the reset edge, and in-flight read data is discarded.

## Timing
- Command handshake on edge k (read burst):
  - First RAM address is sampled on edge k+1.
  - First `rd_valid` appears after edge k+2.
- With `rd_ready` held high, read throughput is one word per cycle.
- Write throughput is one word per cycle. Handshake edge = RAM write edge.
- `done` is high for exactly one cycle, in the cycle the FSM is back in IDLE.
- A new command can be accepted in the same cycle `done` is high.
- `rd_data` is stable while `rd_valid`=1 and `rd_ready`=0.

## Configuration
- **`RAM_BURST_ABORT_EN` defined:** adds input port `abort` (1 bit).
  - `abort`=1 in WRITE: go to IDLE and pulse `done`.
  - `abort`=1 in READ: go to DRAIN; in-flight words are still delivered.
  - `abort` is ignored in IDLE and DRAIN.
- **`RAM_BURST_ABORT_EN` undefined:** no `abort` port; bursts always run to length.

## Test plan
- **Reset, then write burst:** write `cmd_addr`=0, `cmd_len`=2, data 01/02/03 with `wr_valid` held high → `ram_we` high for 3 cycles, addresses 0,1,2; `done` pulses once.
- **Read back:** read `cmd_addr`=0, `cmd_len`=2, `rd_ready`=1 → `rd_data` 01, 02, 03 on consecutive cycles, first `rd_valid` 2 edges after the handshake; `done` after the third pop.
- **Backpressure:** same read with `rd_ready` low for 4 cycles → at most 2 addresses issued, 01 held stable on `rd_data`, no word lost or duplicated after release.
- **Wrap:** write `cmd_addr`=62, `cmd_len`=3, data A0..A3 → RAM addresses 62,63,0,1; readback at 62 returns A0..A3.
- **Reset mid-read:** `rst` asserted while the buffer holds 2 words → next cycle `rd_valid`=0, `busy`=0, `ram_we`=0, no `done`.
- **With `RAM_BURST_ABORT_EN`:** `abort` after 2 of 8 write words → exactly 2 RAM writes, `done` pulses, `cmd_ready` returns to 1.
